vga_timing_gen_s0: RTL and testbench

- Stage-0 source of the VGA display pipeline.
- Free-running horizontal and vertical counters generate `h_sync_s0`, `v_sync_s0`, `DE_s0`, `x_pixel_s0` and `y_pixel_s0`.
- These feed the s0→s1 pipeline register and everything downstream.
- Default timing is 640x480@60 Hz on a 25 MHz `pclk`. All outputs are registered so stage 0 starts from a clean flop boundary.

---
 rtl/vga_timing_gen_s0.sv | 119 +++++++++++
 tb/tb_vga_timing_gen_s0.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_s0.sv
// Stage-0 VGA timing source: free-running h/v counters with registered sync, DE and pixel coordinates.
// Optional VGA_FRAME_PULSE_EN adds a registered frame_start_s0 pulse aligned with output (0,0).
module vga_timing_gen_s0 #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       pclk,
  input  logic       reset_n,
  output logic       DE_s0,
  output logic       h_sync_s0,
  output logic       v_sync_s0,
  output logic [9:0] x_pixel_s0,
`ifdef VGA_FRAME_PULSE_EN
  output logic [9:0] y_pixel_s0,
  output logic       frame_start_s0
`else
  output logic [9:0] y_pixel_s0
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Thresholds held at 11 bits so a 1024-count total still compares cleanly.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_last, v_last;

  logic       de_q, de_d;
  logic       h_sync_q, h_sync_d;
  logic       v_sync_q, v_sync_d;
  logic [9:0] x_pixel_q, x_pixel_d;
  logic [9:0] y_pixel_q, y_pixel_d;
  logic [10:0] h_ext, v_ext;

  // Counter next-state: v advances only on the h wrap; both wrap together on the last pixel.
  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
    end
  end

  // Decode of the current count; registered below so outputs lag the counters by one pclk.
  always_comb begin
    h_ext     = {1'b0, h_cnt_q};
    v_ext     = {1'b0, v_cnt_q};
    de_d      = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
    h_sync_d  = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    v_sync_d  = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    x_pixel_d = h_cnt_q;
    y_pixel_d = v_cnt_q;
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      de_q      <= 1'b0;
      h_sync_q  <= ~SYNC_POL;
      v_sync_q  <= ~SYNC_POL;
      x_pixel_q <= '0;
      y_pixel_q <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      de_q      <= de_d;
      h_sync_q  <= h_sync_d;
      v_sync_q  <= v_sync_d;
      x_pixel_q <= x_pixel_d;
      y_pixel_q <= y_pixel_d;
    end
  end

  assign DE_s0      = de_q;
  assign h_sync_s0  = h_sync_q;
  assign v_sync_s0  = v_sync_q;
  assign x_pixel_s0 = x_pixel_q;
  assign y_pixel_s0 = y_pixel_q;

`ifdef VGA_FRAME_PULSE_EN
  logic frame_start_q, frame_start_d;

  always_comb begin
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start_s0 = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen_s0.sv
// Directed bench for vga_timing_gen_s0 using reduced timings so full frames fit a short run.
module tb_vga_timing_gen_s0;

  // Main instance: H 10/2/3/1 (16), V 6/2/2/1 (11), active-low syncs; frame = 176 cycles.
  // Polarity instance: H 4/1/2/1 (8), V 2/1/1/1 (5), active-high syncs; frame = 40 cycles.
  logic       pclk;
  logic       reset_n;
  logic       de_m, hs_m, vs_m;
  logic [9:0] x_m, y_m;
  logic       de_p, hs_p, vs_p;
  logic [9:0] x_p, y_p;
`ifdef VGA_FRAME_PULSE_EN
  logic       fs_m, fs_p;
`endif

  int chk_cnt;
  int pass_cnt;
  int cyc;

  vga_timing_gen_s0 #(
    .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b0)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .DE_s0(de_m), .h_sync_s0(hs_m), .v_sync_s0(vs_m),
`ifdef VGA_FRAME_PULSE_EN
    .x_pixel_s0(x_m), .y_pixel_s0(y_m), .frame_start_s0(fs_m)
`else
    .x_pixel_s0(x_m), .y_pixel_s0(y_m)
`endif
  );

  vga_timing_gen_s0 #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1)
  ) dut_p (
    .pclk(pclk), .reset_n(reset_n), .DE_s0(de_p), .h_sync_s0(hs_p), .v_sync_s0(vs_p),
`ifdef VGA_FRAME_PULSE_EN
    .x_pixel_s0(x_p), .y_pixel_s0(y_p), .frame_start_s0(fs_p)
`else
    .x_pixel_s0(x_p), .y_pixel_s0(y_p)
`endif
  );

  initial pclk = 1'b0;
  always #20 pclk = ~pclk;

  // Expected {DE, h_sync, v_sync, x, y} for output index c after release, main instance.
  function automatic logic [22:0] exp_main(input int c);
    int x, y;
    logic de, hs, vs;
    x  = c % 16;
    y  = (c / 16) % 11;
    de = (x < 10) && (y < 6);
    hs = !((x >= 12) && (x <= 14));
    vs = !((y >= 8) && (y <= 9));
    return {de, hs, vs, 10'(x), 10'(y)};
  endfunction

  function automatic logic [22:0] exp_pol(input int c);
    int x, y;
    logic de, hs, vs;
    x  = c % 8;
    y  = (c / 8) % 5;
    de = (x < 4) && (y < 2);
    hs = (x == 5) || (x == 6);
    vs = (y == 3);
    return {de, hs, vs, 10'(x), 10'(y)};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge pclk);
    chk_cnt++;
    if ({de_m, hs_m, vs_m, x_m, y_m} !== {1'b0, 1'b1, 1'b1, 10'd0, 10'd0})
      $display("FAIL reset_main got=%h exp=%h", {de_m, hs_m, vs_m, x_m, y_m}, {3'b011, 20'd0});
    else pass_cnt++;
    chk_cnt++;
    if ({de_p, hs_p, vs_p, x_p, y_p} !== 23'd0)
      $display("FAIL reset_pol got=%h exp=%h", {de_p, hs_p, vs_p, x_p, y_p}, 23'd0);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge pclk);
    cyc = 0;
    chk_cnt++;
    if ({de_m, x_m, y_m} !== {1'b1, 10'd0, 10'd0})
      $display("FAIL release_first got de=%b x=%0d y=%0d exp de=1 x=0 y=0", de_m, x_m, y_m);
    else pass_cnt++;
  endtask

  task automatic test_line();
    int de_n, hs_n, hs_first;
    de_n = 0; hs_n = 0; hs_first = -1;
    for (int i = 0; i < 17; i++) begin
      chk_cnt++;
      if ({de_m, hs_m, vs_m, x_m, y_m} !== exp_main(cyc))
        $display("FAIL line_cyc%0d got=%h exp=%h", cyc, {de_m, hs_m, vs_m, x_m, y_m}, exp_main(cyc));
      else pass_cnt++;
      if (i < 16) begin
        if (de_m) de_n++;
        if (!hs_m) begin
          hs_n++;
          if (hs_first < 0) hs_first = int'(x_m);
        end
      end
      @(negedge pclk);
      cyc++;
    end
    chk_cnt++;
    if (de_n !== 10) $display("FAIL line_de_count got=%0d exp=10", de_n);
    else pass_cnt++;
    chk_cnt++;
    if (hs_n !== 3 || hs_first !== 12)
      $display("FAIL line_hsync got count=%0d start=%0d exp count=3 start=12", hs_n, hs_first);
    else pass_cnt++;
  endtask

  task automatic test_polarity();
    for (int i = 0; i < 45; i++) begin
      chk_cnt++;
      if ({de_p, hs_p, vs_p, x_p, y_p} !== exp_pol(cyc))
        $display("FAIL pol_cyc%0d got=%h exp=%h", cyc, {de_p, hs_p, vs_p, x_p, y_p}, exp_pol(cyc));
      else pass_cnt++;
      @(negedge pclk);
      cyc++;
    end
  endtask

  task automatic test_frame();
    int de_n, vs_n, vs_run, vs_best, wraps;
    de_n = 0; vs_n = 0; vs_run = 0; vs_best = 0; wraps = 0;
    for (int i = 0; i < 176; i++) begin
      chk_cnt++;
      if ({de_m, hs_m, vs_m, x_m, y_m} !== exp_main(cyc))
        $display("FAIL frame_cyc%0d got=%h exp=%h", cyc, {de_m, hs_m, vs_m, x_m, y_m}, exp_main(cyc));
      else pass_cnt++;
      if (de_m) de_n++;
      if (!vs_m) begin
        vs_n++;
        vs_run++;
        if (vs_run > vs_best) vs_best = vs_run;
      end else vs_run = 0;
      if (x_m == 10'd0 && y_m == 10'd0) wraps++;
      @(negedge pclk);
      cyc++;
    end
    chk_cnt++;
    if (de_n !== 60) $display("FAIL frame_de_count got=%0d exp=60", de_n);
    else pass_cnt++;
    chk_cnt++;
    if (vs_n !== 32 || vs_best !== 32)
      $display("FAIL frame_vsync got total=%0d run=%0d exp total=32 run=32", vs_n, vs_best);
    else pass_cnt++;
    chk_cnt++;
    if (wraps !== 1) $display("FAIL frame_origin_count got=%0d exp=1", wraps);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    // Advance to output x=3, y=2 of the current frame.
    while ((cyc % 176) != 35) begin
      @(negedge pclk);
      cyc++;
    end
    chk_cnt++;
    if ({x_m, y_m} !== {10'd3, 10'd2}) $display("FAIL mid_pre got x=%0d y=%0d exp x=3 y=2", x_m, y_m);
    else pass_cnt++;
    reset_n = 1'b0;
    @(negedge pclk);
    chk_cnt++;
    if ({de_m, hs_m, vs_m, x_m, y_m} !== {3'b011, 20'd0})
      $display("FAIL mid_reset got=%h exp=%h", {de_m, hs_m, vs_m, x_m, y_m}, {3'b011, 20'd0});
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge pclk);
    cyc = 0;
    for (int i = 0; i < 17; i++) begin
      chk_cnt++;
      if ({de_m, hs_m, vs_m, x_m, y_m} !== exp_main(cyc))
        $display("FAIL mid_after_cyc%0d got=%h exp=%h", cyc, {de_m, hs_m, vs_m, x_m, y_m}, exp_main(cyc));
      else pass_cnt++;
      @(negedge pclk);
      cyc++;
    end
  endtask

`ifdef VGA_FRAME_PULSE_EN
  task automatic test_frame_pulse();
    int pulses, first_at, second_at;
    pulses = 0; first_at = -1; second_at = -1;
    reset_n = 1'b0;
    @(negedge pclk);
    chk_cnt++;
    if (fs_m !== 1'b0 || fs_p !== 1'b0) $display("FAIL fs_reset got m=%b p=%b exp 0 0", fs_m, fs_p);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge pclk);
    cyc = 0;
    for (int i = 0; i < 177; i++) begin
      chk_cnt++;
      if (fs_m !== ((cyc % 176) == 0) || fs_p !== ((cyc % 40) == 0))
        $display("FAIL fs_cyc%0d got m=%b p=%b exp m=%b p=%b", cyc, fs_m, fs_p,
                 (cyc % 176) == 0, (cyc % 40) == 0);
      else pass_cnt++;
      if (fs_m) begin
        pulses++;
        if (first_at < 0) first_at = cyc;
        else second_at = cyc;
      end
      @(negedge pclk);
      cyc++;
    end
    chk_cnt++;
    if (pulses !== 2 || (second_at - first_at) !== 176)
      $display("FAIL fs_period got pulses=%0d gap=%0d exp pulses=2 gap=176", pulses, second_at - first_at);
    else pass_cnt++;
  endtask
`endif

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    cyc = 0;
    reset_n = 1'b0;
    @(negedge pclk);
    test_reset();
    test_line();
    test_polarity();
    test_frame();
    test_mid_reset();
`ifdef VGA_FRAME_PULSE_EN
    test_frame_pulse();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
